// File: rtl/mult_pkg.sv
// Shared constants and request/response records for the multiplier issue shell.
package mult_pkg;
  localparam int XLEN         = 64;
  localparam int MULT_LATENCY = 8;
  localparam int TAG_W        = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
  } mult_req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  product;
  } mult_resp_t;
endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Request, multiplier-side and response signals of the issue shell.
interface mult_issue_ctrl_if;
  import mult_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  req_mcand;
  logic [XLEN-1:0]  req_mplier;

  logic             mult_start;
  logic [XLEN-1:0]  mult_mcand;
  logic [XLEN-1:0]  mult_mplier;
  logic             mult_done;
  logic [XLEN-1:0]  mult_product;

  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  resp_product;

  modport slave (
    input  req_valid, req_tag, req_mcand, req_mplier, mult_done, mult_product, resp_ready,
    output req_ready, mult_start, mult_mcand, mult_mplier, resp_valid, resp_tag, resp_product
  );

  modport master (
    output req_valid, req_tag, req_mcand, req_mplier, mult_done, mult_product, resp_ready,
    input  req_ready, mult_start, mult_mcand, mult_mplier, resp_valid, resp_tag, resp_product
  );
endinterface

// File: rtl/mult_resp_fifo.sv
// Synchronous result FIFO; an occupancy counter separates full from empty for any DEPTH.
module mult_resp_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  mult_resp_t                   din,
  output mult_resp_t                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  mult_resp_t     mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mult_issue_ctrl.sv
// Credit-gated issue/retire shell around a fixed-latency, non-stallable multiplier.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic                        clock,
  input  logic                        reset,
  mult_issue_ctrl_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]  outstanding,
  output logic                        seq_err
);
  localparam int CW = $clog2(DEPTH+1);

  mult_req_t                   req;
  mult_resp_t                  wdata, head;
  logic                        accept, pop, last_vld;
  logic                        cap, drop_done, drop_tag, wr_drop, release_credit;
  logic                        fifo_full, fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [LATENCY-1:0]          vld_pipe;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe;

  assign req = '{tag: bus.req_tag, mcand: bus.req_mcand, mplier: bus.req_mplier};

  // Admission looks only at the registered credit count, so ready never depends on valid.
  assign bus.req_ready   = reset & (outstanding < CW'(DEPTH));
  assign accept          = bus.req_valid & bus.req_ready;
  assign bus.mult_start  = accept;
  assign bus.mult_mcand  = req.mcand;
  assign bus.mult_mplier = req.mplier;

  assign last_vld       = vld_pipe[LATENCY-1];
  assign cap            = last_vld & bus.mult_done;
  assign drop_done      = bus.mult_done & ~last_vld;
  assign drop_tag       = last_vld & ~bus.mult_done;
  assign wr_drop        = cap & fifo_full;
  assign release_credit = drop_tag | wr_drop;
  assign pop            = bus.resp_valid & bus.resp_ready;

  assign wdata = '{tag: tag_pipe[LATENCY-1], product: bus.mult_product};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      tag_pipe    <= '0;
      outstanding <= '0;
      seq_err     <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[LATENCY-2:0], accept};
      tag_pipe    <= {tag_pipe[LATENCY-2:0], req.tag};
      outstanding <= outstanding + CW'(accept) - CW'(pop) - CW'(release_credit);
      if (drop_done | drop_tag | wr_drop) seq_err <= 1'b1;
    end
  end

  mult_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cap & ~fifo_full),
    .pop   (pop),
    .din   (wdata),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.resp_valid   = ~fifo_empty;
  assign bus.resp_tag     = head.tag;
  assign bus.resp_product = head.product;

  // Every buffered result still holds the credit taken when it was issued.
  a_credit_covers_fifo: assert property (@(posedge clock) disable iff (!reset) fifo_count <= outstanding);
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench: accepted requests push expected results, a monitor pops on each response handshake.
module tb_mult_issue_ctrl;
  import mult_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = MULT_LATENCY;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] outstanding;
  logic          seq_err;
  logic          inj_done = 1'b0;

  always #5 clock = ~clock;

  mult_issue_ctrl_if bus();

  mult_issue_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .outstanding (outstanding),
    .seq_err     (seq_err)
  );

  // Behavioural 8-stage multiplier sharing the block reset
  logic [LAT-1:0]           m_vld;
  logic [LAT-1:0][XLEN-1:0] m_prod;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_vld  <= '0;
      m_prod <= '0;
    end else begin
      m_vld  <= {m_vld[LAT-2:0], bus.mult_start};
      m_prod <= {m_prod[LAT-2:0], bus.mult_mcand * bus.mult_mplier};
    end
  end
  assign bus.mult_done    = m_vld[LAT-1] | inj_done;
  assign bus.mult_product = m_prod[LAT-1];

  int passed = 0, total = 0;
  int cyc = 0, n_resp = 0, first_pop = -1, last_pop = -1, stalls = 0;
  logic [XLEN-1:0] cur_exp;
  logic            last_start;
  mult_resp_t      expq[$];
  mult_resp_t      e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard push on accept, pop/compare on response handshake
  always @(negedge clock) begin
    if (reset && bus.req_valid && bus.req_ready)
      expq.push_back('{tag: bus.req_tag, product: cur_exp});
    if (reset && bus.resp_valid && bus.resp_ready) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got tag %h product %h expected none", bus.resp_tag, bus.resp_product);
      end else begin
        e = expq.pop_front();
        chk("resp_tag", 64'(bus.resp_tag), 64'(e.tag));
        chk("resp_product", bus.resp_product, e.product);
      end
      if (n_resp == 0) first_pop = cyc;
      last_pop = cyc;
      n_resp++;
    end
  end

  task automatic issue(input logic [TAG_W-1:0] t, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] x);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_tag = t; bus.req_mcand = a; bus.req_mplier = b; cur_exp = x;
    do begin @(negedge clock); n++; end while (!bus.req_ready && n < 200);
    if (!bus.req_ready) begin
      total++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 within 200 cycles");
    end
    if (n > 1) stalls++;
    last_start = bus.mult_start;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int want, input int budget);
    int n = 0;
    while (n_resp < want && n < budget) begin @(negedge clock); n++; end
    chk("resp_count", 64'(n_resp), 64'(want));
  endtask

  initial begin
    int early, acc, ready_err, resp_snap;
    bus.req_valid = 1'b1; bus.req_tag = '0; bus.req_mcand = '0; bus.req_mplier = '0;
    bus.resp_ready = 1'b0; cur_exp = '0;

    // Reset state, with a request held to prove admission is blocked
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_mult_start", 64'(bus.mult_start), 0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_seq_err", 64'(seq_err), 0);
    bus.req_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock); #1;

    // Single op: 7*6 = 42, response exactly LATENCY+1 cycles after start
    bus.resp_ready = 1'b1;
    issue(4'd3, 64'd7, 64'd6, 64'd42);
    chk("single_start", 64'(last_start), 1);
    early = 0;
    repeat (LAT) begin @(negedge clock); if (bus.resp_valid) early++; end
    chk("single_no_early", 64'(early), 0);
    @(negedge clock);
    chk("single_resp_valid", 64'(bus.resp_valid), 1);
    @(negedge clock);
    chk("single_outstanding", 64'(outstanding), 0);

    // Back-to-back: 20 ops, no stall, 20 consecutive responses
    n_resp = 0; stalls = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 20; i++) issue(4'(i), 64'(i), 64'(i+1), 64'(i*(i+1)));
    wait_resp(20, 40);
    chk("b2b_stalls", 64'(stalls), 0);
    chk("b2b_consecutive", 64'(last_pop - first_pop), 19);

    // Backpressure: only DEPTH accepted, ready drops at the credit limit
    @(posedge clock); #1;
    bus.resp_ready = 1'b0; n_resp = 0; acc = 0; ready_err = 0;
    for (int i = 0; i < 20; i++) begin
      bus.req_valid = 1'b1; bus.req_tag = 4'(i); bus.req_mcand = 64'(i+100); bus.req_mplier = 64'd3;
      cur_exp = 64'((i+100)*3);
      @(negedge clock);
      if (bus.req_ready) acc++;
      if (bus.req_ready !== (i < 16)) ready_err++;
      @(posedge clock); #1;
    end
    bus.req_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 16);
    chk("bp_ready_pattern", 64'(ready_err), 0);
    repeat (LAT + 2) @(negedge clock);
    chk("bp_outstanding_full", 64'(outstanding), 16);
    chk("bp_head_stable_tag", 64'(bus.resp_tag), 0);
    chk("bp_head_stable_prod", bus.resp_product, 64'd300);
    @(posedge clock); #1 bus.resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_ready_still_low", 64'(bus.req_ready), 0);
    @(negedge clock);
    chk("bp_ready_reassert", 64'(bus.req_ready), 1);
    wait_resp(16, 40);
    chk("bp_drain_rate", 64'(last_pop - first_pop), 15);
    chk("bp_outstanding_zero", 64'(outstanding), 0);

    // Wrap arithmetic on the low 64 bits
    n_resp = 0;
    @(posedge clock); #1;
    issue(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(4'd6, 64'h1_0000_0000, 64'h1_0000_0000, 64'h0);
    wait_resp(2, 30);

    // Reset mid-flight discards everything
    bus.resp_ready = 1'b0; n_resp = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) issue(4'(i+8), 64'(i+2), 64'd5, 64'((i+2)*5));
    repeat (3) @(posedge clock); #1;
    reset = 1'b0; #1;
    chk("midrst_outstanding", 64'(outstanding), 0);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 0);
    chk("midrst_req_ready", 64'(bus.req_ready), 0);
    expq.delete();
    repeat (2) @(posedge clock); #1 reset = 1'b1;
    bus.resp_ready = 1'b1;
    repeat (12) @(negedge clock);
    chk("postrst_no_stale", 64'(n_resp), 0);
    chk("postrst_outstanding", 64'(outstanding), 0);
    chk("postrst_seq_err", 64'(seq_err), 0);

    // Error injection: done with an empty tag pipe
    @(posedge clock); #1 inj_done = 1'b1;
    @(posedge clock); #1 inj_done = 1'b0;
    resp_snap = n_resp;
    @(negedge clock);
    chk("err_seq_err_set", 64'(seq_err), 1);
    chk("err_resp_valid", 64'(bus.resp_valid), 0);
    repeat (6) @(negedge clock);
    chk("err_seq_err_sticky", 64'(seq_err), 1);
    chk("err_outstanding", 64'(outstanding), 0);
    chk("err_no_resp", 64'(n_resp), 64'(resp_snap));
    chk("sb_empty", 64'(expq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
